pc_gen: RTL and testbench

Parametrised program-counter generator for the RISC_Interrupt pipeline, placed in front of instruction fetch. It holds the architectural fetch PC in a register and drives it to fetch with a valid/ready handshake. Each cycle it selects the next PC by priority: trap vector (direct or vectored `mtvec`), `mret` return to `mepc`, resolved branch redirect from EX, or sequential advance. It also adds a post-reset bubble, a WFI sleep state, and a check for misaligned redirect targets.

---
 rtl/pc_gen_pkg.sv | 27 ++
 rtl/pc_gen_if.sv | 11 +
 rtl/pc_redirect_sel.sv | 51 +++++
 rtl/pc_gen.sv | 116 +++++++++++
 tb/tb_pc_gen.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and trap-vector arithmetic for the fetch PC generator.
// Vector math is done at a fixed 64-bit width; callers truncate to XLEN.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WFI  = 2'd2
  } pcg_state_e;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;
  localparam int         TV_W           = 64;

  // Modes other than vectored fall back to direct, as does any synchronous trap.
  function automatic logic [TV_W-1:0] trap_vec(input logic [TV_W-1:0] mtvec,
                                               input logic            irq,
                                               input logic [TV_W-1:0] cause);
    logic [TV_W-1:0] base;
    base = {mtvec[TV_W-1:2], 2'b00};
    if (irq && (mtvec[1:0] == MTVEC_VECTORED)) begin
      return base + (cause << 2);
    end
    return base;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side handshake: PC generator is master, instruction fetch is slave.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic            pc_vld;
  logic            fetch_rdy;

  modport master (output pc, output pc_vld, input  fetch_rdy);
  modport slave  (input  pc, input  pc_vld, output fetch_rdy);
endinterface

// File: rtl/pc_redirect_sel.sv
// Combinational redirect arbitration: trap > mret > branch, with target
// formation and rejection of misaligned branch targets.
module pc_redirect_sel
  import pc_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) (
  input  logic               i_en,
  input  logic               i_trap_vld,
  input  logic               i_trap_irq,
  input  logic [CAUSE_W-1:0] i_trap_cause,
  input  logic [XLEN-1:0]    i_mtvec,
  input  logic               i_mret_vld,
  input  logic [XLEN-1:0]    i_mepc,
  input  logic               i_br_vld,
  input  logic [XLEN-1:0]    i_br_tgt,
  output logic               o_redir,
  output logic [XLEN-1:0]    o_tgt,
  output logic               o_misalign
);

  logic [TV_W-1:0] w_vec;
  logic            w_br_sel;
  logic            w_br_ok;

  assign w_vec    = trap_vec(TV_W'(i_mtvec), i_trap_irq, TV_W'(i_trap_cause));
  assign w_br_ok  = (i_br_tgt[1:0] == 2'b00);
  // A branch only counts as misaligned when it would actually have won arbitration.
  assign w_br_sel = i_en & i_br_vld & ~i_trap_vld & ~i_mret_vld;

  assign o_misalign = w_br_sel & ~w_br_ok;
  assign o_redir    = i_en & (i_trap_vld | i_mret_vld | (i_br_vld & w_br_ok));

  always_comb begin
    o_tgt = i_br_tgt;
    if (i_trap_vld) begin
      o_tgt = w_vec[XLEN-1:0];
    end else if (i_mret_vld) begin
      o_tgt = {i_mepc[XLEN-1:2], 2'b00};
    end
  end

  generate
    if (XLEN < TV_W) begin : g_vec_hi
      logic w_unused_vec_hi;
      assign w_unused_vec_hi = ^w_vec[TV_W-1:XLEN];
    end
  endgenerate

endmodule

// File: rtl/pc_gen.sv
// Architectural fetch PC register with BOOT/RUN/WFI control and
// priority redirect handling, driving fetch over a valid/ready handshake.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              CAUSE_W   = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_trap_vld,
  input  logic               i_trap_irq,
  input  logic [CAUSE_W-1:0] i_trap_cause,
  input  logic [XLEN-1:0]    i_mtvec,
  input  logic               i_mret_vld,
  input  logic [XLEN-1:0]    i_mepc,
  input  logic               i_br_vld,
  input  logic [XLEN-1:0]    i_br_tgt,
  input  logic               i_wfi_vld,
  input  logic [XLEN-1:0]    i_wfi_pc,
  input  logic               i_irq_pend,
  pc_gen_if.master           if_fetch,
  output logic               o_flush,
  output logic               o_br_misalign,
  output logic               o_sleep
);

  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  pcg_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_vld, w_vld_nxt;
  logic            r_sleep;
  logic            w_en;
  logic            w_redir;
  logic [XLEN-1:0] w_tgt;

  assign w_en = (r_state != BOOT);

  pc_redirect_sel #(
    .XLEN    (XLEN),
    .CAUSE_W (CAUSE_W)
  ) u_sel (
    .i_en         (w_en),
    .i_trap_vld   (i_trap_vld),
    .i_trap_irq   (i_trap_irq),
    .i_trap_cause (i_trap_cause),
    .i_mtvec      (i_mtvec),
    .i_mret_vld   (i_mret_vld),
    .i_mepc       (i_mepc),
    .i_br_vld     (i_br_vld),
    .i_br_tgt     (i_br_tgt),
    .o_redir      (w_redir),
    .o_tgt        (w_tgt),
    .o_misalign   (o_br_misalign)
  );

  // Accepted redirects bypass the fetch handshake entirely.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_vld_nxt   = r_vld;
    if (w_redir) begin
      w_state_nxt = RUN;
      w_pc_nxt    = w_tgt;
      w_vld_nxt   = 1'b1;
    end else begin
      unique case (r_state)
        BOOT: w_state_nxt = RUN;
        RUN: begin
          if (i_wfi_vld) begin
            w_state_nxt = WFI;
            w_pc_nxt    = i_wfi_pc + PC_INC;
            w_vld_nxt   = 1'b0;
          end else begin
            if (r_vld && if_fetch.fetch_rdy) begin
              w_pc_nxt = r_pc + PC_INC;
            end
            w_vld_nxt = 1'b1;
          end
        end
        WFI: begin
          if (i_irq_pend) begin
            w_state_nxt = RUN;
            w_vld_nxt   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = BOOT;
          w_vld_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_VEC;
      r_vld   <= 1'b0;
      r_sleep <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_vld   <= w_vld_nxt;
      r_sleep <= (w_state_nxt == WFI);
    end
  end

  assign if_fetch.pc     = r_pc;
  assign if_fetch.pc_vld = r_vld;
  assign o_flush         = w_redir;
  assign o_sleep         = r_sleep;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/boot, stall, traps, priority, misalign, WFI, wrap.
module tb_pc_gen;

  localparam int XLEN = 32;

  logic              clk;
  logic              rst_n;
  logic              trap_vld, trap_irq, mret_vld, br_vld, wfi_vld, irq_pend;
  logic [4:0]        trap_cause;
  logic [XLEN-1:0]   mtvec, mepc, br_tgt, wfi_pc;
  logic              flush, misalign, sleep;
  int                checks;
  int                errors;

  pc_gen_if #(.XLEN(XLEN)) u_if ();

  pc_gen #(
    .XLEN      (XLEN),
    .RESET_VEC (32'h0000_0100),
    .CAUSE_W   (5)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_trap_vld    (trap_vld),
    .i_trap_irq    (trap_irq),
    .i_trap_cause  (trap_cause),
    .i_mtvec       (mtvec),
    .i_mret_vld    (mret_vld),
    .i_mepc        (mepc),
    .i_br_vld      (br_vld),
    .i_br_tgt      (br_tgt),
    .i_wfi_vld     (wfi_vld),
    .i_wfi_pc      (wfi_pc),
    .i_irq_pend    (irq_pend),
    .if_fetch      (u_if),
    .o_flush       (flush),
    .o_br_misalign (misalign),
    .o_sleep       (sleep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (u_if.pc !== 32'h100) begin errors++; $display("FAIL reset_pc got %h exp %h", u_if.pc, 32'h100); end
    checks++; if (u_if.pc_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", u_if.pc_vld); end
    checks++; if (sleep !== 1'b0) begin errors++; $display("FAIL reset_sleep got %b exp 0", sleep); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    rst_n  = 1'b1;
    br_vld = 1'b1;
    br_tgt = 32'h200;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL boot_flush got %b exp 0", flush); end
    step();
    br_vld = 1'b0;
    checks++; if (u_if.pc_vld !== 1'b0) begin errors++; $display("FAIL boot_bubble_vld got %b exp 0", u_if.pc_vld); end
    checks++; if (u_if.pc !== 32'h100) begin errors++; $display("FAIL boot_pc got %h exp %h", u_if.pc, 32'h100); end
    step();
    checks++; if (u_if.pc_vld !== 1'b1) begin errors++; $display("FAIL first_vld got %b exp 1", u_if.pc_vld); end
    checks++; if (u_if.pc !== 32'h100) begin errors++; $display("FAIL seq0 got %h exp %h", u_if.pc, 32'h100); end
    step();
    checks++; if (u_if.pc !== 32'h104) begin errors++; $display("FAIL seq1 got %h exp %h", u_if.pc, 32'h104); end
    step();
    checks++; if (u_if.pc !== 32'h108) begin errors++; $display("FAIL seq2 got %h exp %h", u_if.pc, 32'h108); end
  endtask

  task automatic test_stall();
    u_if.fetch_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (u_if.pc !== 32'h108) begin errors++; $display("FAIL stall_pc[%0d] got %h exp %h", i, u_if.pc, 32'h108); end
      checks++; if (u_if.pc_vld !== 1'b1) begin errors++; $display("FAIL stall_vld[%0d] got %b exp 1", i, u_if.pc_vld); end
    end
    br_vld = 1'b1;
    br_tgt = 32'h200;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_br_flush got %b exp 1", flush); end
    step();
    br_vld = 1'b0;
    u_if.fetch_rdy = 1'b1;
    checks++; if (u_if.pc !== 32'h200) begin errors++; $display("FAIL stall_br_pc got %h exp %h", u_if.pc, 32'h200); end
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stall_br_flush_end got %b exp 0", flush); end
  endtask

  task automatic test_trap();
    trap_vld   = 1'b1;
    trap_irq   = 1'b1;
    trap_cause = 5'd7;
    mtvec      = 32'h8000_0001;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL trap_flush got %b exp 1", flush); end
    step();
    checks++; if (u_if.pc !== 32'h8000_001C) begin errors++; $display("FAIL trap_vectored got %h exp %h", u_if.pc, 32'h8000_001C); end
    checks++; if (u_if.pc_vld !== 1'b1) begin errors++; $display("FAIL trap_vld got %b exp 1", u_if.pc_vld); end
    trap_irq = 1'b0;
    step();
    trap_vld = 1'b0;
    checks++; if (u_if.pc !== 32'h8000_0000) begin errors++; $display("FAIL trap_sync got %h exp %h", u_if.pc, 32'h8000_0000); end
  endtask

  task automatic test_priority();
    trap_vld = 1'b1;
    trap_irq = 1'b0;
    mret_vld = 1'b1;
    mepc     = 32'h400;
    br_vld   = 1'b1;
    br_tgt   = 32'h300;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL prio_flush got %b exp 1", flush); end
    step();
    trap_vld = 1'b0;
    mret_vld = 1'b0;
    br_vld   = 1'b0;
    checks++; if (u_if.pc !== 32'h8000_0000) begin errors++; $display("FAIL prio_trap got %h exp %h", u_if.pc, 32'h8000_0000); end
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL prio_single_pulse got %b exp 0", flush); end
    step();
    checks++; if (u_if.pc !== 32'h8000_0004) begin errors++; $display("FAIL prio_seq got %h exp %h", u_if.pc, 32'h8000_0004); end
    mret_vld = 1'b1;
    br_vld   = 1'b1;
    step();
    mret_vld = 1'b0;
    br_vld   = 1'b0;
    checks++; if (u_if.pc !== 32'h400) begin errors++; $display("FAIL prio_mret got %h exp %h", u_if.pc, 32'h400); end
  endtask

  task automatic test_misalign();
    br_vld = 1'b1;
    br_tgt = 32'h302;
    #1;
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_flag got %b exp 1", misalign); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL misalign_flush got %b exp 0", flush); end
    step();
    br_vld = 1'b0;
    checks++; if (u_if.pc !== 32'h404) begin errors++; $display("FAIL misalign_seq got %h exp %h", u_if.pc, 32'h404); end
    #1;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b exp 0", misalign); end
  endtask

  task automatic test_wfi();
    wfi_vld = 1'b1;
    wfi_pc  = 32'h50;
    step();
    wfi_vld = 1'b0;
    checks++; if (sleep !== 1'b1) begin errors++; $display("FAIL wfi_sleep got %b exp 1", sleep); end
    checks++; if (u_if.pc_vld !== 1'b0) begin errors++; $display("FAIL wfi_vld got %b exp 0", u_if.pc_vld); end
    checks++; if (u_if.pc !== 32'h54) begin errors++; $display("FAIL wfi_pc got %h exp %h", u_if.pc, 32'h54); end
    step();
    checks++; if (u_if.pc !== 32'h54) begin errors++; $display("FAIL wfi_hold_pc got %h exp %h", u_if.pc, 32'h54); end
    checks++; if (sleep !== 1'b1) begin errors++; $display("FAIL wfi_hold_sleep got %b exp 1", sleep); end
    irq_pend = 1'b1;
    step();
    irq_pend = 1'b0;
    checks++; if (u_if.pc_vld !== 1'b1) begin errors++; $display("FAIL wake_vld got %b exp 1", u_if.pc_vld); end
    checks++; if (u_if.pc !== 32'h54) begin errors++; $display("FAIL wake_pc got %h exp %h", u_if.pc, 32'h54); end
    checks++; if (sleep !== 1'b0) begin errors++; $display("FAIL wake_sleep got %b exp 0", sleep); end
    step();
    checks++; if (u_if.pc !== 32'h58) begin errors++; $display("FAIL wake_seq got %h exp %h", u_if.pc, 32'h58); end
    wfi_vld = 1'b1;
    step();
    wfi_vld = 1'b0;
    checks++; if (sleep !== 1'b1) begin errors++; $display("FAIL wfi2_sleep got %b exp 1", sleep); end
    trap_vld   = 1'b1;
    trap_irq   = 1'b1;
    trap_cause = 5'd3;
    mtvec      = 32'h8000_0001;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL wfi_trap_flush got %b exp 1", flush); end
    step();
    trap_vld = 1'b0;
    checks++; if (u_if.pc !== 32'h8000_000C) begin errors++; $display("FAIL wfi_trap_pc got %h exp %h", u_if.pc, 32'h8000_000C); end
    checks++; if (sleep !== 1'b0) begin errors++; $display("FAIL wfi_trap_sleep got %b exp 0", sleep); end
    checks++; if (u_if.pc_vld !== 1'b1) begin errors++; $display("FAIL wfi_trap_vld got %b exp 1", u_if.pc_vld); end
  endtask

  task automatic test_back_to_back();
    wfi_vld = 1'b1;
    wfi_pc  = 32'h50;
    br_vld  = 1'b1;
    br_tgt  = 32'h600;
    step();
    wfi_vld = 1'b0;
    br_vld  = 1'b0;
    checks++; if (u_if.pc !== 32'h600) begin errors++; $display("FAIL wfi_vs_br_pc got %h exp %h", u_if.pc, 32'h600); end
    checks++; if (sleep !== 1'b0) begin errors++; $display("FAIL wfi_vs_br_sleep got %b exp 0", sleep); end
    mret_vld = 1'b1;
    mepc     = 32'h0000_0703;
    step();
    mret_vld = 1'b0;
    checks++; if (u_if.pc !== 32'h700) begin errors++; $display("FAIL mret_align got %h exp %h", u_if.pc, 32'h700); end
    br_vld = 1'b1;
    br_tgt = 32'hFFFF_FFFC;
    step();
    br_vld = 1'b0;
    checks++; if (u_if.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h exp %h", u_if.pc, 32'hFFFF_FFFC); end
    step();
    checks++; if (u_if.pc !== 32'h0) begin errors++; $display("FAIL wrap_post got %h exp %h", u_if.pc, 32'h0); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b1;
    trap_vld       = 1'b0;
    trap_irq       = 1'b0;
    trap_cause     = '0;
    mtvec          = '0;
    mret_vld       = 1'b0;
    mepc           = '0;
    br_vld         = 1'b0;
    br_tgt         = '0;
    wfi_vld        = 1'b0;
    wfi_pc         = '0;
    irq_pend       = 1'b0;
    u_if.fetch_rdy = 1'b1;
    #2;
    test_reset();
    test_stall();
    test_trap();
    test_priority();
    test_misalign();
    test_wfi();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
